mem_access_ctrl: RTL and testbench

Load/store initiator for the word-organised data memory (combinational read, write on `clk` rising edge when `mem_write`=1, word index `address[31:2]`). It sits between the datapath and that memory. It accepts byte, halfword and word requests through a valid/ready handshake and turns sub-word stores into a read-modify-write sequence. It extracts and sign/zero-extends load data, and reports misaligned or out-of-range accesses without touching memory.

---
 rtl/mem_access_ctrl.sv | 155 +++++++++++++++
 tb/tb_mem_access_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - load/store initiator with sub-word read-modify-write for a word-organised memory
module mem_access_ctrl #(
  parameter int unsigned RAM_SIZE = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    MERGE_WR,
    RESP
  } state_t;

  state_t      state;
  logic        write_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] merge_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;

  function automatic logic req_bad(input logic [1:0] size, input logic [31:0] addr);
    logic misaligned;
    logic out_of_range;
    misaligned   = ((size == SZ_HALF) && addr[0]) ||
                   ((size == SZ_WORD) && (addr[1:0] != 2'b00));
    out_of_range = ({2'b00, addr[31:2]} >= 32'(RAM_SIZE));
    return (size == SZ_ILL) || misaligned || out_of_range;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] off, input logic sgn);
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;
    shifted = word >> {off, 3'b000};
    b = shifted[7:0];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: return {{24{sgn & b[7]}}, b};
      SZ_HALF: return {{16{sgn & h[15]}}, h};
      default: return word;
    endcase
  endfunction

  // Only the addressed lane is replaced; every other bit of the read word survives.
  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] data,
                                              input logic [1:0] size, input logic [1:0] off);
    logic [31:0] mask;
    logic [31:0] lane;
    logic [4:0]  sh;
    if (size == SZ_BYTE) begin
      sh   = {off, 3'b000};
      mask = 32'h0000_00ff << sh;
      lane = {24'h0, data[7:0]} << sh;
    end else begin
      sh   = {off[1], 4'b0000};
      mask = 32'h0000_ffff << sh;
      lane = {16'h0, data[15:0]} << sh;
    end
    return (word & ~mask) | lane;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      write_q     <= 1'b0;
      size_q      <= SZ_BYTE;
      signed_q    <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      merge_q     <= 32'h0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            write_q     <= req_write;
            size_q      <= req_size;
            signed_q    <= req_signed;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            rsp_rdata_q <= 32'h0;
            if (req_bad(req_size, req_addr)) begin
              rsp_err_q <= 1'b1;
              state     <= RESP;
            end else begin
              rsp_err_q <= 1'b0;
              state     <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (!write_q) begin
            rsp_rdata_q <= load_extract(mem_read_data, size_q, addr_q[1:0], signed_q);
            state       <= RESP;
          end else if (size_q == SZ_WORD) begin
            state <= RESP;
          end else begin
            merge_q <= store_merge(mem_read_data, wdata_q, size_q, addr_q[1:0]);
            state   <= MERGE_WR;
          end
        end
        MERGE_WR: state <= RESP;
        RESP: begin
          rsp_rdata_q <= 32'h0;
          rsp_err_q   <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory-side signals depend on state and captured request only, so reset kills them at once.
  logic word_store_now;
  logic accessing;

  assign word_store_now = (state == ACCESS) && write_q && (size_q == SZ_WORD);
  assign accessing      = (state == ACCESS) || (state == MERGE_WR);

  assign req_ready      = (state == IDLE);
  assign rsp_valid      = (state == RESP);
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_err        = rsp_err_q;
  assign mem_write      = word_store_now || (state == MERGE_WR);
  assign mem_address    = accessing ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem_write_data = (state == MERGE_WR) ? merge_q :
                          word_store_now      ? wdata_q : 32'h0;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - scoreboard bench for mem_access_ctrl with randomized loads/stores
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  mem_access_ctrl #(.RAM_SIZE(256)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_write(mem_write), .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  // Attached memory: combinational read, write on rising edge.
  logic [31:0] mem [0:255];
  assign mem_read_data = (mem_address[31:10] == 22'h0) ? mem[mem_address[9:2]] : 32'h0;
  always @(posedge clk) if (mem_write) mem[mem_address[9:2]] <= mem_write_data;

  // Reference model: expected memory contents after every accepted request.
  int unsigned ref_mem [0:255];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
    int          wcnt;
    logic [31:0] wdata;
    logic [31:0] waddr;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, expv, cyc);
  endtask

  function automatic bit ref_bad(input int unsigned size, input int unsigned addr);
    if (size == 3) return 1;
    if (size == 1 && (addr % 2) != 0) return 1;
    if (size == 2 && (addr % 4) != 0) return 1;
    return (addr / 4) >= 256;
  endfunction

  function automatic int unsigned ref_load(input int unsigned size, input bit sgn, input int unsigned addr);
    int unsigned w, v, sh;
    w  = ref_mem[addr / 4];
    sh = (addr % 4) * 8;
    if (size == 2) return w;
    if (size == 0) begin
      v = (w >> sh) & 255;
      if (sgn && v >= 128) v = v - 256;
    end else begin
      v = (w >> sh) & 65535;
      if (sgn && v >= 32768) v = v - 65536;
    end
    return v;
  endfunction

  task automatic ref_store(input int unsigned size, input int unsigned addr, input int unsigned d);
    int unsigned w, sh, mask;
    if (size == 2) begin
      ref_mem[addr / 4] = d;
    end else begin
      w    = ref_mem[addr / 4];
      sh   = (addr % 4) * 8;
      mask = ((size == 0) ? 32'd255 : 32'd65535) << sh;
      ref_mem[addr / 4] = (w & ~mask) | ((d << sh) & mask);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic issue(input bit wr, input logic [1:0] size, input bit sgn,
                       input logic [31:0] addr, input logic [31:0] wdata, input bit keep);
    exp_t e;
    int b;
    req_write = wr; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    b = 0;
    while (!req_ready && b < 50) begin
      @(negedge clk);
      b++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    e.acc = cyc + 1;
    e.wdata = 32'h0;
    e.waddr = 32'h0;
    e.rdata = 32'h0;
    if (ref_bad(size, addr)) begin
      e.err = 1'b1; e.lat = 1; e.wcnt = 0;
    end else if (!wr) begin
      e.err = 1'b0; e.lat = 2; e.wcnt = 0;
      e.rdata = ref_load(size, sgn, addr);
    end else begin
      ref_store(size, addr, wdata);
      e.err = 1'b0; e.lat = (size == 2'b10) ? 2 : 3; e.wcnt = 1;
      e.wdata = ref_mem[addr / 4];
      e.waddr = addr & 32'hffff_fffc;
    end
    @(posedge clk);
    exp_q.push_back(e);
    @(negedge clk);
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic drain();
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < 100) begin
      @(negedge clk);
      b++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: write activity and responses are compared against the scoreboard queue.
  int wr_cnt = 0;
  logic [31:0] last_wdata = 32'h0;
  logic [31:0] last_waddr = 32'h0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      wr_cnt = 0;
    end else begin
      if (mem_write) begin
        wr_cnt++;
        last_wdata = mem_write_data;
        last_waddr = mem_address;
      end
      if (exp_q.size() != 0) chk("ready_busy", 32'(req_ready), 32'd0);
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
          chk("rsp_latency", 32'(cyc - e.acc + 1), 32'(e.lat));
          chk("write_count", 32'(wr_cnt), 32'(e.wcnt));
          if (e.wcnt != 0) begin
            chk("write_data", last_wdata, e.wdata);
            chk("write_addr", last_waddr, e.waddr);
          end
        end
        wr_cnt = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 32'h0;
      ref_mem[i] = 0;
    end
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mem_address", mem_address, 32'h0);
    chk("rst_mem_wdata", mem_write_data, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0);
    issue(0, 2'b10, 0, 32'h10, 32'h0, 0);
    issue(1, 2'b10, 0, 32'h20, 32'h11223344, 0);
    issue(1, 2'b00, 0, 32'h22, 32'h000000AA, 0);
    issue(0, 2'b10, 0, 32'h20, 32'h0, 0);
    issue(1, 2'b10, 0, 32'h30, 32'h000080F0, 0);
    issue(0, 2'b00, 1, 32'h31, 32'h0, 0);
    issue(0, 2'b00, 0, 32'h31, 32'h0, 0);
    issue(0, 2'b01, 1, 32'h30, 32'h0, 0);
    issue(0, 2'b01, 0, 32'h33, 32'h0, 0);
    issue(0, 2'b10, 0, 32'h42, 32'h0, 0);
    issue(0, 2'b11, 0, 32'h10, 32'h0, 0);
    issue(0, 2'b10, 0, 32'h400, 32'h0, 0);
    issue(1, 2'b01, 0, 32'h402, 32'h1234, 0);
    drain();
    chk("dir_ref_merge", ref_mem[8], 32'h11AA3344);

    // Reset during MERGE_WR must abort the write and the response.
    issue(1, 2'b10, 0, 32'h50, 32'hCAFEBABE, 0);
    drain();
    req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h52; req_wdata = 32'h55; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("merge_wr_write", 32'(mem_write), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("reset_drops_write", 32'(mem_write), 32'd0);
    chk("reset_no_rsp", 32'(rsp_valid), 32'd0);
    chk("reset_ready", 32'(req_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    issue(0, 2'b10, 0, 32'h50, 32'h0, 0);
    drain();
    chk("after_reset_word", ref_mem[20], 32'hCAFEBABE);

    // Back-to-back with req_valid held throughout.
    issue(1, 2'b01, 0, 32'h52, 32'h0000BEEF, 1);
    issue(0, 2'b00, 1, 32'h53, 32'h0, 1);
    issue(0, 2'b10, 0, 32'h50, 32'h0, 0);
    drain();

    for (int n = 0; n < 200; n++) begin
      logic [31:0] a;
      logic [1:0]  sz;
      a  = ($urandom_range(0, 9) == 0) ? $urandom() : 32'($urandom_range(0, 63));
      sz = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom(),
            1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        req_valid = 1'b0;
        repeat ($urandom_range(1, 2)) @(negedge clk);
      end
    end
    req_valid = 1'b0;
    drain();
    for (int i = 0; i < 16; i++) chk("final_mem", mem[i], ref_mem[i]);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
